// File: rtl/fpga_reset_sequencer.sv
// Board reset conditioner: debounced button, synchronized lock and software request
// combine into a held, synchronously released active-low reset for x_heep_system.
module fpga_reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int HOLD_CYCLES     = 64,
  parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_i,
  input  logic       locked_i,
  input  logic       sw_rst_req_i,
  output logic       rst_no,
  output logic       rst_led_o,
  output logic [1:0] state_o,
  output logic [7:0] rst_count_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] btn_sync_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   btn_n;
  logic                   btn_s;
  logic                   lock_s;
  logic                   btn_db_q, btn_db_d;
  logic [DW-1:0]          deb_cnt_q, deb_cnt_d;
  logic                   fault;

  state_e                 state_q;
  logic [HW-1:0]          hold_cnt_q;
  logic                   rst_n_q;
  logic                   led_q;
  logic [7:0]             cnt_q;

  assign btn_n  = btn_i ^ BTN_ACTIVE_LOW;
  assign btn_s  = btn_sync_q[SYNC_STAGES-1];
  assign lock_s = lock_sync_q[SYNC_STAGES-1];
  assign fault  = btn_db_q | ~lock_s;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btn_sync_q  <= '0;
      lock_sync_q <= '0;
      btn_db_q    <= 1'b0;
      deb_cnt_q   <= '0;
    end else begin
      btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], btn_n};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], locked_i};
      btn_db_q    <= btn_db_d;
      deb_cnt_q   <= deb_cnt_d;
    end
  end

  // The counter only runs while the synchronized button disagrees with btn_db.
  always_comb begin
    btn_db_d  = btn_db_q;
    deb_cnt_d = '0;
    if (btn_s != btn_db_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        btn_db_d = btn_s;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_WAIT;
      hold_cnt_q <= '0;
      rst_n_q    <= 1'b0;
      led_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      unique case (state_q)
        S_WAIT: begin
          if (!fault) begin
            state_q    <= S_HOLD;
            hold_cnt_q <= '0;
          end
        end
        S_HOLD: begin
          if (fault) begin
            state_q <= S_WAIT;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_q <= S_RUN;
            rst_n_q <= 1'b1;
            led_q   <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + HW'(1);
          end
        end
        S_RUN: begin
          if (fault || sw_rst_req_i) begin
            rst_n_q <= 1'b0;
            led_q   <= 1'b0;
            if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
            if (fault) begin
              state_q <= S_WAIT;
            end else begin
              state_q    <= S_HOLD;
              hold_cnt_q <= '0;
            end
          end
        end
        default: begin
          state_q <= S_WAIT;
          rst_n_q <= 1'b0;
          led_q   <= 1'b0;
        end
      endcase
    end
  end

  assign rst_no      = rst_n_q;
  assign rst_led_o   = led_q;
  assign state_o     = state_q;
  assign rst_count_o = cnt_q;

endmodule

// File: tb/tb_fpga_reset_sequencer.sv
// Directed bench for fpga_reset_sequencer with short debounce/hold settings.
module tb_fpga_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       btn_i;
  logic       locked_i;
  logic       sw_rst_req_i;
  logic       rst_no;
  logic       rst_led_o;
  logic [1:0] state_o;
  logic [7:0] rst_count_o;

  int errs   = 0;
  int checks = 0;
  int exp_cnt;

  fpga_reset_sequencer #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(8),
    .HOLD_CYCLES(4),
    .BTN_ACTIVE_LOW(1'b0)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .btn_i(btn_i),
    .locked_i(locked_i),
    .sw_rst_req_i(sw_rst_req_i),
    .rst_no(rst_no),
    .rst_led_o(rst_led_o),
    .state_o(state_o),
    .rst_count_o(rst_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // After lock (re)appears: 2 sync edges, WAIT->HOLD, 4 hold edges.
  task automatic release_seq(input string tag);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk({tag, "_st"}, state_o, (i < 3) ? 0 : (i < 7) ? 1 : 2);
      chk({tag, "_rst"}, rst_no, (i == 7) ? 1 : 0);
    end
    chk({tag, "_led"}, rst_led_o, 1);
  endtask

  initial begin
    rst_i        = 1'b1;
    btn_i        = 1'b0;
    locked_i     = 1'b0;
    sw_rst_req_i = 1'b0;
    exp_cnt      = 0;
    repeat (3) tick();
    chk("rst_rstno", rst_no, 0);
    chk("rst_led", rst_led_o, 0);
    chk("rst_state", state_o, 0);
    chk("rst_cnt", rst_count_o, 0);

    // 1) power-up
    rst_i = 1'b0;
    repeat (20) tick();
    chk("pu_wait_st", state_o, 0);
    chk("pu_wait_rst", rst_no, 0);
    locked_i = 1'b1;
    release_seq("pu");

    // 2) short glitch ignored, long press resets
    btn_i = 1'b1;
    repeat (5) tick();
    btn_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("glitch_rst", rst_no, 1);
    end
    btn_i = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("press_rst", rst_no, (i < 11) ? 1 : 0);
    end
    exp_cnt++;
    chk("press_cnt", rst_count_o, exp_cnt);
    btn_i = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("rel_st", state_o, (i < 11) ? 0 : (i < 15) ? 1 : 2);
      chk("rel_rst", rst_no, (i == 15) ? 1 : 0);
    end

    // 3) software reset
    sw_rst_req_i = 1'b1;
    tick();
    sw_rst_req_i = 1'b0;
    chk("sw_rst0", rst_no, 0);
    chk("sw_st0", state_o, 1);
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk("sw_rst", rst_no, (i == 5) ? 1 : 0);
    end
    exp_cnt++;
    chk("sw_cnt", rst_count_o, exp_cnt);

    // 4) lock loss during HOLD restarts the sequence
    sw_rst_req_i = 1'b1;
    tick();
    sw_rst_req_i = 1'b0;
    exp_cnt++;
    chk("ll_st0", state_o, 1);
    locked_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("ll_st", state_o, (i < 3) ? 1 : 0);
      chk("ll_rst", rst_no, 0);
    end
    locked_i = 1'b1;
    release_seq("ll");
    chk("ll_cnt", rst_count_o, exp_cnt);

    // 5) fault wins over a simultaneous sw request
    locked_i = 1'b0;
    tick();
    tick();
    chk("pri_pre_st", state_o, 2);
    sw_rst_req_i = 1'b1;
    tick();
    sw_rst_req_i = 1'b0;
    exp_cnt++;
    chk("pri_st", state_o, 0);
    chk("pri_rst", rst_no, 0);
    chk("pri_cnt", rst_count_o, exp_cnt);
    locked_i = 1'b1;
    release_seq("pri");

    // 6) counter saturation, then async reset mid-RUN
    for (int n = 0; n < 300; n++) begin
      sw_rst_req_i = 1'b1;
      tick();
      sw_rst_req_i = 1'b0;
      repeat (4) tick();
      if (exp_cnt < 255) exp_cnt++;
    end
    chk("sat_cnt", rst_count_o, 255);
    chk("sat_exp", rst_count_o, exp_cnt);
    chk("sat_st", state_o, 2);
    chk("sat_rst", rst_no, 1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_rst", rst_no, 0);
    chk("arst_led", rst_led_o, 0);
    chk("arst_st", state_o, 0);
    chk("arst_cnt", rst_count_o, 0);
    tick();
    rst_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
